// File: rtl/rlc_stream_decoder.sv
// Run-length decoder: fetches a packed MSB-first (value, run) bitstream from SRAM
// and expands it into LANES-wide output beats on a valid/ready stream.
module rlc_stream_decoder #(
    parameter int unsigned WORD_W = 16,
    parameter int unsigned VAL_W  = 4,
    parameter int unsigned RUN_W  = 2,
    parameter int unsigned LANES  = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [15:0]            num_elems,
    input  logic [WORD_W-1:0]      sram_din,
    input  logic                   sram_valid,
    output logic                   sram_req,
    output logic [VAL_W*LANES-1:0] out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   done,
    output logic                   overrun
);

    localparam int unsigned OutW     = VAL_W * LANES;
    localparam int unsigned BufW     = 2 * WORD_W;
    localparam int unsigned SymW     = VAL_W + RUN_W;
    localparam int unsigned FillW    = $clog2(BufW + 1);
    localparam int unsigned LaneCntW = $clog2(LANES + 1);
    localparam int unsigned CntW     = RUN_W + 1;

    localparam logic [FillW-1:0]    SymBits  = FillW'(SymW);
    localparam logic [FillW-1:0]    WordBits = FillW'(WORD_W);
    localparam logic [LaneCntW-1:0] LaneMax  = LaneCntW'(LANES);

    typedef enum logic [2:0] {
        StIdle,
        StFill,
        StParse,
        StExpand,
        StFlush,
        StDone
    } state_e;

    state_e              state_q, state_d;
    logic [BufW-1:0]     buf_q, buf_d;
    logic [FillW-1:0]    fill_q, fill_d;
    logic [15:0]         rem_q, rem_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [VAL_W-1:0]    val_q, val_d;
    logic [OutW-1:0]     lane_q, lane_d;
    logic [LaneCntW-1:0] lane_cnt_q, lane_cnt_d;
    logic [OutW-1:0]     out_q, out_d;
    logic                out_valid_q, out_valid_d;
    logic                overrun_q, overrun_d;
    logic                req_q, req_d;

    logic                accept;
    logic                out_free;
    logic                xfer;
    logic                insert;
    logic [BufW-1:0]     buf_shift;
    logic [FillW-1:0]    fill_pop;
    logic [OutW-1:0]     base_lane;
    logic [LaneCntW-1:0] base_cnt;
    int unsigned         lane_shift;

    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        fill_d      = fill_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        val_d       = val_q;
        lane_d      = lane_q;
        lane_cnt_d  = lane_cnt_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        overrun_d   = overrun_q;
        req_d       = 1'b0;
        base_lane   = lane_q;
        base_cnt    = lane_cnt_q;
        lane_shift  = 0;

        accept   = req_q && sram_valid;
        out_free = !out_valid_q || out_ready;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            out_d       = '0;
        end

        // Pop a symbol (PARSE) first, then append any accepted word just below what remains.
        buf_shift = (state_q == StParse) ? (buf_q << SymW) : buf_q;
        fill_pop  = (state_q == StParse) ? (fill_q - SymBits) : fill_q;
        if (accept) begin
            buf_d  = buf_shift | ({sram_din, {WORD_W{1'b0}}} >> fill_pop);
            fill_d = fill_pop + WordBits;
        end else begin
            buf_d  = buf_shift;
            fill_d = fill_pop;
        end

        // A full (or, in FLUSH, partial) lane register moves to the output slot once it frees.
        if (state_q == StFlush) begin
            xfer = (lane_cnt_q != '0) && out_free;
        end else begin
            xfer = (lane_cnt_q == LaneMax) && out_free;
        end
        if (xfer) begin
            out_d       = lane_q;
            out_valid_d = 1'b1;
            base_lane   = '0;
            base_cnt    = '0;
        end
        lane_d     = base_lane;
        lane_cnt_d = base_cnt;

        insert = (state_q == StExpand) && ((lane_cnt_q != LaneMax) || out_free);
        if (insert) begin
            lane_shift = 32'(base_cnt) * VAL_W;
            lane_d     = base_lane | ({val_q, {(OutW - VAL_W){1'b0}}} >> lane_shift);
            lane_cnt_d = base_cnt + LaneCntW'(1);
            // Completing a beat goes straight to the output slot so out_valid follows next cycle.
            if (lane_cnt_d == LaneMax && out_free && !xfer) begin
                out_d       = lane_d;
                out_valid_d = 1'b1;
                lane_d      = '0;
                lane_cnt_d  = '0;
            end
        end

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    overrun_d  = 1'b0;
                    buf_d      = '0;
                    fill_d     = '0;
                    rem_d      = num_elems;
                    lane_d     = '0;
                    lane_cnt_d = '0;
                    state_d    = (num_elems == '0) ? StDone : StFill;
                end
            end
            StFill: begin
                if (fill_d >= SymBits) begin
                    state_d = StParse;
                end
            end
            StParse: begin
                val_d   = buf_q[BufW-1 -: VAL_W];
                cnt_d   = CntW'(buf_q[BufW-1-VAL_W -: RUN_W]) + CntW'(1);
                state_d = StExpand;
            end
            StExpand: begin
                if (insert) begin
                    cnt_d = cnt_q - CntW'(1);
                    rem_d = rem_q - 16'd1;
                    if (rem_d == '0) begin
                        overrun_d = (cnt_d != '0);
                        state_d   = StFlush;
                    end else if (cnt_d == '0) begin
                        state_d = (fill_d >= SymBits) ? StParse : StFill;
                    end
                end
            end
            StFlush: begin
                if (lane_cnt_q == '0 && (!out_valid_q || out_ready)) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase

        req_d = ((state_d == StFill) || (state_d == StParse) || (state_d == StExpand)) &&
                (fill_d <= WordBits) && (rem_d != '0) && !accept;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            buf_q       <= '0;
            fill_q      <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            val_q       <= '0;
            lane_q      <= '0;
            lane_cnt_q  <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            req_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            fill_q      <= fill_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            val_q       <= val_d;
            lane_q      <= lane_d;
            lane_cnt_q  <= lane_cnt_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
            req_q       <= req_d;
        end
    end

    assign sram_req  = req_q;
    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign done      = (state_q == StDone);
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_rlc_stream_decoder.sv
// Directed bench for rlc_stream_decoder using the stream 0x20F0, 0x0500
// (symbols (2,0) (3,3) (0,0) (1,1)), followed by zero padding words.
module tb_rlc_stream_decoder;

    localparam logic [31:0] BeatFull    = 32'h23333011;
    localparam logic [31:0] BeatPartial = 32'h23333000;
    localparam logic [31:0] BeatTrunc   = 32'h23300000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] num_elems = 16'd0;
    logic [15:0] sram_din;
    logic        sram_valid;
    logic        sram_req;
    logic [31:0] out;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        done;
    logic        overrun;

    logic        model_valid;
    logic [15:0] model_din;
    logic        spur_valid = 1'b0;

    int total = 0;
    int bad = 0;
    int widx = 0;
    int widx_base = 0;
    int lat = 1;
    int beats = 0;
    logic [31:0] last_beat = '0;

    assign sram_valid = model_valid | spur_valid;
    assign sram_din   = spur_valid ? 16'hFFFF : model_din;

    rlc_stream_decoder dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .num_elems  (num_elems),
        .sram_din   (sram_din),
        .sram_valid (sram_valid),
        .sram_req   (sram_req),
        .out        (out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .done       (done),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] word_at(input int idx);
        case (idx)
            0:       return 16'h20F0;
            1:       return 16'h0500;
            default: return 16'h0000;
        endcase
    endfunction

    // SRAM model: answers a request 'lat' cycles later with a one-cycle valid pulse.
    initial begin
        model_valid = 1'b0;
        model_din   = 16'h0000;
        forever begin
            @(negedge clk);
            model_valid = 1'b0;
            if (sram_req === 1'b1) begin
                repeat (lat) @(negedge clk);
                model_din   = word_at(widx - widx_base);
                model_valid = 1'b1;
                if (sram_req === 1'b1) widx++;
            end
        end
    end

    always @(negedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            beats     <= beats + 1;
            last_beat <= out;
        end
    end

    task automatic start_decode(input logic [15:0] n, input int l);
        lat       = l;
        widx_base = widx;
        num_elems = n;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (out_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        total++; if (sram_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", sram_req); end
        total++; if (out !== 32'h0) begin bad++; $display("FAIL reset_out: got %h want 0", out); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        @(negedge clk);
    endtask

    task automatic test_full_beat;
        int b0;
        bit ok;
        b0 = beats;
        start_decode(16'd8, 1);
        total++; if (sram_req !== 1'b1) begin bad++; $display("FAIL full_req_rise: got %b want 1", sram_req); end
        wait_valid(ok);
        total++; if (!ok) begin bad++; $display("FAIL full_valid_timeout: got no out_valid want out_valid"); end
        total++; if (out !== BeatFull) begin bad++; $display("FAIL full_out: got %h want %h", out, BeatFull); end
        @(negedge clk);
        total++; if (done !== 1'b1) begin bad++; $display("FAIL full_done_timing: got %b want 1", done); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL full_overrun: got %b want 0", overrun); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL full_valid_drop: got %b want 0", out_valid); end
        total++; if (beats - b0 != 1) begin bad++; $display("FAIL full_beats: got %0d want 1", beats - b0); end
    endtask

    task automatic test_partial;
        int b0;
        bit ok;
        b0 = beats;
        start_decode(16'd5, 1);
        wait_done(ok);
        total++; if (!ok) begin bad++; $display("FAIL partial_timeout: got no done want done"); end
        total++; if (beats - b0 != 1) begin bad++; $display("FAIL partial_beats: got %0d want 1", beats - b0); end
        total++; if (last_beat !== BeatPartial) begin bad++; $display("FAIL partial_out: got %h want %h", last_beat, BeatPartial); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL partial_overrun: got %b want 0", overrun); end
    endtask

    task automatic test_truncation;
        int b0;
        bit ok;
        b0 = beats;
        start_decode(16'd3, 1);
        wait_done(ok);
        total++; if (!ok) begin bad++; $display("FAIL trunc_timeout: got no done want done"); end
        total++; if (beats - b0 != 1) begin bad++; $display("FAIL trunc_beats: got %0d want 1", beats - b0); end
        total++; if (last_beat !== BeatTrunc) begin bad++; $display("FAIL trunc_out: got %h want %h", last_beat, BeatTrunc); end
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL trunc_overrun: got %b want 1", overrun); end
    endtask

    task automatic test_backpressure(input int l);
        int b0;
        bit ok;
        b0 = beats;
        out_ready = 1'b0;
        start_decode(16'd8, l);
        total++; if (done !== 1'b0 || overrun !== 1'b0) begin
            bad++; $display("FAIL bp_restart_clear lat=%0d: got done=%b overrun=%b want 0 0", l, done, overrun);
        end
        wait_valid(ok);
        total++; if (!ok) begin bad++; $display("FAIL bp_valid_timeout lat=%0d: got no out_valid want out_valid", l); end
        // A start pulse mid-stall must be ignored.
        for (int i = 0; i < 10; i++) begin
            total++; if (out !== BeatFull || out_valid !== 1'b1) begin
                bad++; $display("FAIL bp_hold lat=%0d cyc=%0d: got %h/%b want %h/1", l, i, out, out_valid, BeatFull);
            end
            start     = (i == 4);
            num_elems = (i == 4) ? 16'd3 : 16'd8;
            @(negedge clk);
        end
        start     = 1'b0;
        out_ready = 1'b1;
        wait_done(ok);
        total++; if (!ok) begin bad++; $display("FAIL bp_done_timeout lat=%0d: got no done want done", l); end
        total++; if (beats - b0 != 1) begin bad++; $display("FAIL bp_beats lat=%0d: got %0d want 1", l, beats - b0); end
        total++; if (last_beat !== BeatFull) begin bad++; $display("FAIL bp_out lat=%0d: got %h want %h", l, last_beat, BeatFull); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL bp_overrun lat=%0d: got %b want 0", l, overrun); end
    endtask

    task automatic test_zero_length;
        int b0;
        bit seen_req;
        bit seen_valid;
        b0 = beats;
        seen_req = 1'b0;
        seen_valid = 1'b0;
        start_decode(16'd0, 1);
        total++; if (done !== 1'b1) begin bad++; $display("FAIL zero_done: got %b want 1", done); end
        for (int i = 0; i < 6; i++) begin
            if (sram_req === 1'b1) seen_req = 1'b1;
            if (out_valid === 1'b1) seen_valid = 1'b1;
            @(negedge clk);
        end
        total++; if (seen_req) begin bad++; $display("FAIL zero_req: got 1 want 0"); end
        total++; if (seen_valid) begin bad++; $display("FAIL zero_valid: got 1 want 0"); end
        total++; if (beats != b0) begin bad++; $display("FAIL zero_beats: got %0d want 0", beats - b0); end
    endtask

    task automatic test_spurious;
        int b0;
        bit ok;
        for (int i = 0; i < 3; i++) begin
            spur_valid = 1'b1;
            @(negedge clk);
            spur_valid = 1'b0;
            total++; if (sram_req !== 1'b0 || out_valid !== 1'b0 || done !== 1'b1) begin
                bad++; $display("FAIL spur_idle: got req=%b valid=%b done=%b want 0 0 1", sram_req, out_valid, done);
            end
            @(negedge clk);
        end
        b0 = beats;
        start_decode(16'd8, 2);
        wait_done(ok);
        total++; if (!ok) begin bad++; $display("FAIL spur_timeout: got no done want done"); end
        total++; if (beats - b0 != 1 || last_beat !== BeatFull) begin
            bad++; $display("FAIL spur_out: got %0d beats %h want 1 beats %h", beats - b0, last_beat, BeatFull);
        end
    endtask

    task automatic test_reset_mid;
        int b0;
        bit ok;
        start_decode(16'd8, 1);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (widx - widx_base >= 1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        total++; if (!ok) begin bad++; $display("FAIL rst_mid_fetch_timeout: got no fetch want fetch"); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++; if (sram_req !== 1'b0 || out !== 32'h0 || out_valid !== 1'b0 || done !== 1'b0 || overrun !== 1'b0) begin
            bad++; $display("FAIL rst_mid_outputs: got req=%b out=%h valid=%b done=%b ovr=%b want all 0",
                            sram_req, out, out_valid, done, overrun);
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        b0 = beats;
        start_decode(16'd8, 1);
        wait_done(ok);
        total++; if (!ok) begin bad++; $display("FAIL rst_mid_timeout: got no done want done"); end
        total++; if (beats - b0 != 1) begin bad++; $display("FAIL rst_mid_beats: got %0d want 1", beats - b0); end
        total++; if (last_beat !== BeatFull) begin bad++; $display("FAIL rst_mid_out: got %h want %h", last_beat, BeatFull); end
    endtask

    initial begin
        test_reset;
        test_full_beat;
        test_partial;
        test_truncation;
        test_backpressure(1);
        test_backpressure(5);
        test_zero_length;
        test_spurious;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
